// File: rtl/four_object_offset_gen.sv
// Four-object hit tester for the VGA draw path: per object, a registered drawRequest and
// bitmap offset, with positions and enables double-buffered and committed at start of frame.
module four_object_offset_gen_obj #(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        start_of_frame,
    input  logic [10:0] top_left_x,
    input  logic [10:0] top_left_y,
    input  logic        pos_load,
    input  logic        obj_en,
    output logic        draw_request,
    output logic [10:0] offset_x,
    output logic [10:0] offset_y,
    output logic        pending
);
    logic [10:0] shadow_x, shadow_y, active_x, active_y;
    logic        shadow_en, active_en;
    logic        hit_x, hit_y, hit;

    // 12-bit compare so an object near column/row 2047 clips instead of wrapping to 0
    always_comb begin
        hit_x = ({1'b0, pixel_x} >= {1'b0, active_x}) &&
                ({1'b0, pixel_x} <  {1'b0, active_x} + 12'(OBJECT_WIDTH_X));
        hit_y = ({1'b0, pixel_y} >= {1'b0, active_y}) &&
                ({1'b0, pixel_y} <  {1'b0, active_y} + 12'(OBJECT_HEIGHT_Y));
        hit   = hit_x & hit_y;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            active_x     <= '0;
            active_y     <= '0;
            shadow_en    <= 1'b0;
            active_en    <= 1'b0;
            pending      <= 1'b0;
            draw_request <= 1'b0;
            offset_x     <= '0;
            offset_y     <= '0;
        end else begin
            shadow_en <= obj_en;
            if (pos_load) begin
                shadow_x <= top_left_x;
                shadow_y <= top_left_y;
            end
            // Commit reads the pre-edge shadow; a same-cycle load stays pending for next frame
            if (start_of_frame) begin
                active_en <= shadow_en;
                if (pending) begin
                    active_x <= shadow_x;
                    active_y <= shadow_y;
                end
            end
            if (pos_load)
                pending <= 1'b1;
            else if (start_of_frame)
                pending <= 1'b0;
            draw_request <= hit & active_en;
            offset_x     <= hit ? pixel_x - active_x : '0;
            offset_y     <= hit ? pixel_y - active_y : '0;
        end
    end
endmodule

module four_object_offset_gen #(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic [10:0] topLeftX1,
    input  logic [10:0] topLeftX2,
    input  logic [10:0] topLeftX3,
    input  logic [10:0] topLeftX4,
    input  logic [10:0] topLeftY1,
    input  logic [10:0] topLeftY2,
    input  logic [10:0] topLeftY3,
    input  logic [10:0] topLeftY4,
    input  logic        posLoad1,
    input  logic        posLoad2,
    input  logic        posLoad3,
    input  logic        posLoad4,
    input  logic [3:0]  objEnable,
    output logic [10:0] offsetX1,
    output logic [10:0] offsetX2,
    output logic [10:0] offsetX3,
    output logic [10:0] offsetX4,
    output logic [10:0] offsetY1,
    output logic [10:0] offsetY2,
    output logic [10:0] offsetY3,
    output logic [10:0] offsetY4,
    output logic        drawRequest1,
    output logic        drawRequest2,
    output logic        drawRequest3,
    output logic        drawRequest4,
    output logic [3:0]  posPending
);
    localparam int NUM_OBJ = 4;

    logic [NUM_OBJ-1:0][10:0] tl_x, tl_y, off_x, off_y;
    logic [NUM_OBJ-1:0]       load, draw;

    assign tl_x = {topLeftX4, topLeftX3, topLeftX2, topLeftX1};
    assign tl_y = {topLeftY4, topLeftY3, topLeftY2, topLeftY1};
    assign load = {posLoad4, posLoad3, posLoad2, posLoad1};

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        four_object_offset_gen_obj #(
            .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
            .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
        ) u_obj (
            .clk           (clk),
            .resetN        (resetN),
            .pixel_x       (pixelX),
            .pixel_y       (pixelY),
            .start_of_frame(startOfFrame),
            .top_left_x    (tl_x[i]),
            .top_left_y    (tl_y[i]),
            .pos_load      (load[i]),
            .obj_en        (objEnable[i]),
            .draw_request  (draw[i]),
            .offset_x      (off_x[i]),
            .offset_y      (off_y[i]),
            .pending       (posPending[i])
        );
    end

    assign {drawRequest4, drawRequest3, drawRequest2, drawRequest1} = draw;
    assign {offsetX4, offsetX3, offsetX2, offsetX1} = off_x;
    assign {offsetY4, offsetY3, offsetY2, offsetY1} = off_y;
endmodule

// File: tb/tb_four_object_offset_gen.sv
// Randomized + directed bench for four_object_offset_gen; a frame-level model predicts each
// registered output and a monitor compares against it one cycle later.
module tb_four_object_offset_gen;
    localparam int W = 32;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic [10:0] tlx [4];
    logic [10:0] tly [4];
    logic [3:0]  ld = '0;
    logic [3:0]  objEnable = '0;
    logic [10:0] ox [4];
    logic [10:0] oy [4];
    logic [3:0]  dr, posPending;

    typedef struct {
        logic [3:0]       dr;
        logic [3:0][10:0] ox;
        logic [3:0][10:0] oy;
        logic [3:0]       pend;
    } exp_t;
    exp_t sb[$];

    int checks = 0, fails = 0;
    // Model of the object state: what the game wrote and what the screen shows
    int sh_x[4], sh_y[4], ac_x[4], ac_y[4];
    bit sh_en[4], ac_en[4], pend[4];
    int nx[4], ny[4];

    four_object_offset_gen #(.OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H)) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .topLeftX1(tlx[0]), .topLeftX2(tlx[1]), .topLeftX3(tlx[2]), .topLeftX4(tlx[3]),
        .topLeftY1(tly[0]), .topLeftY2(tly[1]), .topLeftY3(tly[2]), .topLeftY4(tly[3]),
        .posLoad1(ld[0]), .posLoad2(ld[1]), .posLoad3(ld[2]), .posLoad4(ld[3]),
        .objEnable(objEnable),
        .offsetX1(ox[0]), .offsetX2(ox[1]), .offsetX3(ox[2]), .offsetX4(ox[3]),
        .offsetY1(oy[0]), .offsetY2(oy[1]), .offsetY3(oy[2]), .offsetY4(oy[3]),
        .drawRequest1(dr[0]), .drawRequest2(dr[1]), .drawRequest3(dr[2]), .drawRequest4(dr[3]),
        .posPending(posPending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
            sh_en[i] = 0; ac_en[i] = 0; pend[i] = 0;
        end
    endtask

    // One pixel clock: drive inputs at negedge, predict what the next posedge registers
    task automatic step(input int px, input int py, input bit sof, input logic [3:0] en,
                        input logic [3:0] load);
        exp_t e;
        int   old_x[4], old_y[4];
        bit   old_en[4], old_p[4];
        @(negedge clk);
        pixelX = 11'(px); pixelY = 11'(py); startOfFrame = sof; objEnable = en; ld = load;
        for (int i = 0; i < 4; i++) begin
            tlx[i] = 11'(nx[i]); tly[i] = 11'(ny[i]);
        end
        for (int i = 0; i < 4; i++) begin
            bit hit;
            hit = px >= ac_x[i] && px < ac_x[i] + W && py >= ac_y[i] && py < ac_y[i] + H;
            e.dr[i] = hit && ac_en[i];
            e.ox[i] = hit ? 11'(px - ac_x[i]) : 11'd0;
            e.oy[i] = hit ? 11'(py - ac_y[i]) : 11'd0;
            old_x[i] = sh_x[i]; old_y[i] = sh_y[i]; old_en[i] = sh_en[i]; old_p[i] = pend[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (sof) begin
                ac_en[i] = old_en[i];
                if (old_p[i]) begin
                    ac_x[i] = old_x[i]; ac_y[i] = old_y[i]; pend[i] = 0;
                end
            end
            sh_en[i] = en[i];
            if (load[i]) begin
                sh_x[i] = nx[i]; sh_y[i] = ny[i]; pend[i] = 1;
            end
            e.pend[i] = pend[i];
        end
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every registered output set is compared against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("drawRequest%0d", i + 1), int'(dr[i]), int'(e.dr[i]));
                    check($sformatf("offsetX%0d", i + 1), int'(ox[i]), int'(e.ox[i]));
                    check($sformatf("offsetY%0d", i + 1), int'(oy[i]), int'(e.oy[i]));
                end
                check("posPending", int'(posPending), int'(e.pend));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " drawRequest"}, int'(dr), 0);
        check({tag, " posPending"}, int'(posPending), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s offsetX%0d", tag, i + 1), int'(ox[i]), 0);
            check($sformatf("%s offsetY%0d", tag, i + 1), int'(oy[i]), 0);
        end
    endtask

    task automatic set_pos(input int i, input int x, input int y);
        nx[i] = x; ny[i] = y;
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 4; i++) begin
            nx[i] = 0; ny[i] = 0; tlx[i] = '0; tly[i] = '0;
        end
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // Basic hit, corners and just outside
        set_pos(0, 100, 50);
        step(0, 0, 0, 4'b0001, 4'b0001);
        step(0, 0, 1, 4'b0001, 4'b0000);
        step(100, 50, 0, 4'b0001, 4'b0000);
        step(131, 81, 0, 4'b0001, 4'b0000);
        step(132, 50, 0, 4'b0001, 4'b0000);
        step(99, 50, 0, 4'b0001, 4'b0000);

        // Tear-free move: old position holds until start of frame
        set_pos(0, 200, 50);
        step(100, 50, 0, 4'b0001, 4'b0001);
        step(100, 50, 0, 4'b0001, 4'b0000);
        step(100, 50, 1, 4'b0001, 4'b0000);
        step(200, 50, 0, 4'b0001, 4'b0000);
        step(100, 50, 0, 4'b0001, 4'b0000);

        // Load colliding with commit: old shadow commits, new one stays pending
        set_pos(1, 0, 0);
        step(0, 0, 0, 4'b0011, 4'b0010);
        set_pos(1, 10, 10);
        step(10, 10, 1, 4'b0011, 4'b0010);
        step(10, 10, 0, 4'b0011, 4'b0000);
        step(0, 0, 1, 4'b0011, 4'b0000);
        step(10, 10, 0, 4'b0011, 4'b0000);
        step(0, 0, 0, 4'b0011, 4'b0000);

        // Right-edge clip, no wrap
        set_pos(2, 2030, 0);
        step(0, 0, 0, 4'b0111, 4'b0100);
        step(0, 0, 1, 4'b0111, 4'b0000);
        step(2047, 5, 0, 4'b0111, 4'b0000);
        step(5, 5, 0, 4'b0111, 4'b0000);
        step(2029, 5, 0, 4'b0111, 4'b0000);

        // Overlap, then disable object 4
        set_pos(0, 300, 300);
        set_pos(3, 300, 300);
        step(0, 0, 0, 4'b1001, 4'b1001);
        step(0, 0, 1, 4'b1001, 4'b0000);
        step(310, 305, 0, 4'b1001, 4'b0000);
        step(310, 305, 0, 4'b0001, 4'b0000);
        step(310, 305, 1, 4'b0001, 4'b0000);
        step(310, 305, 0, 4'b0001, 4'b0000);
        step(310, 305, 0, 4'b0001, 4'b0000);

        // Async reset in the middle of a hit
        @(posedge clk);
        #3;
        check("pre-reset drawRequest1", int'(dr[0]), 1);
        resetN = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        set_pos(0, 300, 300);
        step(310, 305, 0, 4'b0001, 4'b0001);
        step(310, 305, 0, 4'b0001, 4'b0000);
        step(310, 305, 1, 4'b0001, 4'b0000);
        step(310, 305, 0, 4'b0001, 4'b0000);

        // Random traffic, pixels biased onto live objects
        for (int n = 0; n < 3000; n++) begin
            int px, py, k;
            logic [3:0] load, en;
            bit sof;
            en = objEnable;
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            load = '0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) begin
                    load[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0)
                        set_pos(i, $urandom_range(2000, 2047), $urandom_range(2000, 2047));
                    else
                        set_pos(i, $urandom_range(0, 2047), $urandom_range(0, 2047));
                end
            sof = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) < 7) begin
                k  = $urandom_range(0, 3);
                px = ac_x[k] + $urandom_range(0, W + 7) - 4;
                py = ac_y[k] + $urandom_range(0, H + 7) - 4;
                if (px < 0) px = 0;
                if (px > 2047) px = 2047;
                if (py < 0) py = 0;
                if (py > 2047) py = 2047;
            end else begin
                px = $urandom_range(0, 2047);
                py = $urandom_range(0, 2047);
            end
            step(px, py, sof, en, load);
        end

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left unchecked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
